// File: rtl/datapath_seq_ctrl_pkg.sv
// datapath_seq_ctrl_pkg: shared encodings for the fetch/execute sequencer
package datapath_seq_ctrl_pkg;
    typedef enum logic [1:0] {S_IDLE, S_FETCH, S_EXEC, S_HALT} state_t;
    localparam logic [3:0] CL_RR   = 4'h0;
    localparam logic [3:0] CL_MOVI = 4'h1;
    localparam logic [3:0] CL_ADDI = 4'h2;
    localparam logic [3:0] CL_MFL  = 4'h3;
    localparam logic [3:0] CL_JMP  = 4'h4;
    localparam logic [3:0] CL_BR   = 4'h5;
    localparam logic [3:0] CL_HALT = 4'hF;
    localparam logic [1:0] B_REG = 2'd0;
    localparam logic [1:0] B_IMM = 2'd1;
    localparam logic [1:0] B_FLG = 2'd2;
    localparam int FL_N = 4;
    localparam int FL_F = 3;
    localparam int FL_Z = 2;
    localparam int FL_L = 1;
    localparam int FL_C = 0;
    localparam logic [3:0] OP_ADD = 4'h0;
    localparam logic [3:0] OP_CMP = 4'h7;
    // mask bit 3 tests both N and F; bits 2..0 test Z, L, C
    function automatic logic br_taken(input logic [3:0] mask, input logic [4:0] fl);
        return |(mask & {fl[FL_F], fl[FL_Z], fl[FL_L], fl[FL_C]}) | (mask[3] & fl[FL_N]);
    endfunction
endpackage

// File: rtl/datapath_seq_ctrl_if.sv
// datapath_seq_ctrl_if: instruction-memory fetch port
interface datapath_seq_ctrl_if #(parameter int PC_W = 8);
    logic            mem_req;
    logic [PC_W-1:0] mem_addr;
    logic [15:0]     mem_rdata;
    logic            mem_ack;
    modport master (output mem_req, mem_addr, input mem_rdata, mem_ack);
    modport slave  (input mem_req, mem_addr, output mem_rdata, mem_ack);
endinterface

// File: rtl/datapath_seq_ctrl_decode.sv
// datapath_seq_ctrl_decode: instruction word to one cycle of datapath controls
module datapath_seq_ctrl_decode
    import datapath_seq_ctrl_pkg::*;
(
    input  logic [15:0] ir,
    input  logic        exec_valid,
    output logic [15:0] reg_en,
    output logic [3:0]  reg_a,
    output logic [3:0]  reg_b,
    output logic [15:0] imm,
    output logic [1:0]  b_sel,
    output logic [3:0]  opcode,
    output logic        flag_en,
    output logic        is_jmp,
    output logic        is_br,
    output logic        is_halt,
    output logic        is_illegal
);
    logic [3:0]  rd;
    logic [15:0] sx;
    logic        wr;
    assign rd = ir[11:8];
    assign sx = {{8{ir[7]}}, ir[7:0]};
    // decode by class; everything idles outside EXEC and r0 is never written
    always_comb begin
        reg_a = '0;
        reg_b = '0;
        imm = '0;
        b_sel = B_REG;
        opcode = OP_ADD;
        flag_en = 1'b0;
        wr = 1'b0;
        is_jmp = 1'b0;
        is_br = 1'b0;
        is_halt = 1'b0;
        is_illegal = 1'b0;
        if (exec_valid) begin
            case (ir[15:12])
                CL_RR: begin
                    reg_a = rd;
                    reg_b = ir[3:0];
                    opcode = ir[7:4];
                    flag_en = 1'b1;
                    wr = ir[7:4] != OP_CMP;
                end
                CL_MOVI: begin
                    imm = sx;
                    b_sel = B_IMM;
                    wr = 1'b1;
                end
                CL_ADDI: begin
                    reg_a = rd;
                    imm = sx;
                    b_sel = B_IMM;
                    flag_en = 1'b1;
                    wr = 1'b1;
                end
                CL_MFL: begin
                    b_sel = B_FLG;
                    wr = 1'b1;
                end
                CL_JMP:  is_jmp = 1'b1;
                CL_BR:   is_br = 1'b1;
                CL_HALT: is_halt = 1'b1;
                default: is_illegal = 1'b1;
            endcase
        end
        reg_en = (wr && rd != 4'd0) ? 16'd1 << rd : 16'd0;
    end
endmodule

// File: rtl/datapath_seq_ctrl.sv
// datapath_seq_ctrl: fetch/execute sequencer driving the register-file/ALU datapath
module datapath_seq_ctrl
    import datapath_seq_ctrl_pkg::*;
#(
    parameter int              PC_W     = 8,
    parameter logic [PC_W-1:0] RESET_PC = '0
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                start,
    datapath_seq_ctrl_if.master mem,
    input  logic [4:0]          flags,
    output logic [15:0]         reg_en,
    output logic [3:0]          reg_a,
    output logic [3:0]          reg_b,
    output logic [15:0]         imm,
    output logic [1:0]          b_sel,
    output logic [3:0]          opcode,
    output logic                flag_en,
    output logic [PC_W-1:0]     pc,
    output logic                halted,
    output logic                illegal
);
    state_t             state;
    logic [15:0]        ir;
    logic               req_q;
    logic [PC_W-1:0]    next_pc;
    logic signed [15:0] sx;
    logic               is_jmp, is_br, is_halt, is_illegal;
    assign mem.mem_req = req_q;
    assign mem.mem_addr = pc;
    assign sx = {{8{ir[7]}}, ir[7:0]};
    datapath_seq_ctrl_decode u_decode (
        .ir(ir),
        .exec_valid(state == S_EXEC),
        .reg_en(reg_en),
        .reg_a(reg_a),
        .reg_b(reg_b),
        .imm(imm),
        .b_sel(b_sel),
        .opcode(opcode),
        .flag_en(flag_en),
        .is_jmp(is_jmp),
        .is_br(is_br),
        .is_halt(is_halt),
        .is_illegal(is_illegal)
    );
    // jump target, flag-conditional relative branch, or sequential wrap-around
    always_comb begin
        next_pc = is_jmp ? PC_W'(ir[7:0])
                : (is_br && br_taken(ir[11:8], flags)) ? pc + PC_W'(sx)
                : pc + PC_W'(1);
    end
    // sequencer FSM with registered request/halt outputs, pc, ir and sticky illegal
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= S_IDLE;
            pc <= RESET_PC;
            ir <= '0;
            illegal <= 1'b0;
            req_q <= 1'b0;
            halted <= 1'b0;
        end else begin
            case (state)
                S_IDLE: if (start) begin
                    state <= S_FETCH;
                    req_q <= 1'b1;
                end
                S_FETCH: if (mem.mem_ack) begin
                    ir <= mem.mem_rdata;
                    state <= S_EXEC;
                    req_q <= 1'b0;
                end
                S_EXEC: if (is_halt || is_illegal) begin
                    state <= S_HALT;
                    halted <= 1'b1;
                    illegal <= illegal | is_illegal;
                end else begin
                    pc <= next_pc;
                    state <= S_FETCH;
                    req_q <= 1'b1;
                end
                S_HALT: if (start) begin
                    pc <= RESET_PC;
                    illegal <= 1'b0;
                    halted <= 1'b0;
                    state <= S_FETCH;
                    req_q <= 1'b1;
                end
            endcase
        end
    end
endmodule
